// File: rtl/lbm_step_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | lbm_step_sequencer_if: lattice BRAM port, collision pipeline and setup/stream buses. |
// | Revision 1.0                                                                          |
// +--------------------------------------------------------------------------------------+
interface lbm_step_sequencer_if #(
  parameter int Q  = 9,
  parameter int W  = 8,
  parameter int AW = 15
);
  logic [Q*AW-1:0] addr_out;
  logic [Q*W-1:0]  bram_data_out;
  logic            we_out;
  logic [Q*W-1:0]  bram_data_in;

  logic [Q*W-1:0]  coll_data_out;
  logic            coll_valid_out;
  logic [Q*W-1:0]  coll_data_in;
  logic            coll_valid_in;

  logic            setup_done_in;
  logic [Q*AW-1:0] setup_addr_in;
  logic [Q*W-1:0]  setup_data_in;
  logic            setup_we_in;

  logic            stream_start_out;
  logic            stream_done_in;
  logic [Q*AW-1:0] stream_addr_in;
  logic [Q*W-1:0]  stream_data_in;
  logic            stream_we_in;

  modport master (
    output addr_out, bram_data_out, we_out, coll_data_out, coll_valid_out, stream_start_out,
    input  bram_data_in, coll_data_in, coll_valid_in,
    input  setup_done_in, setup_addr_in, setup_data_in, setup_we_in,
    input  stream_done_in, stream_addr_in, stream_data_in, stream_we_in
  );

  modport slave (
    input  addr_out, bram_data_out, we_out, coll_data_out, coll_valid_out, stream_start_out,
    output bram_data_in, coll_data_in, coll_valid_in,
    output setup_done_in, setup_addr_in, setup_data_in, setup_we_in,
    output stream_done_in, stream_addr_in, stream_data_in, stream_we_in
  );
endinterface
`default_nettype wire

// File: rtl/lbm_step_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | lbm_step_sequencer: SETUP once, then COLLIDE/STREAM/WAIT timesteps on the BRAM port.  |
// | Revision 1.0                                                                          |
// +--------------------------------------------------------------------------------------+
module lbm_step_sequencer #(
  parameter int HPIXELS     = 160,
  parameter int VPIXELS     = 120,
  parameter int Q           = 9,
  parameter int W           = 8,
  parameter int RD_LAT      = 2,
  parameter int COLL_LAT    = 4,
  parameter int WAIT_CYCLES = 1024
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 run_in,
  input  logic                 step_in,
  lbm_step_sequencer_if.master bus,
  output logic [2:0]           state_out,
  output logic [15:0]          step_count_out
);
  localparam int DEPTH = HPIXELS * VPIXELS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam int WCW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0]  DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0]  LAST_C    = CW'(DEPTH - 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_CYCLES - 1);

  if (RD_LAT < 1 || COLL_LAT < 1 || WAIT_CYCLES < 1) begin : g_param_check
    $error("lbm_step_sequencer: RD_LAT, COLL_LAT and WAIT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_SETUP   = 3'd0,
    S_COLLIDE = 3'd1,
    S_STREAM  = 3'd2,
    S_WAIT    = 3'd3,
    S_PAUSE   = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     rd_cnt, rd_nx, wr_cnt, wr_nx;
  logic [WCW-1:0]    wait_cnt, wait_nx;
  logic              phase, phase_nx;
  logic              hold_v, hold_v_nx;
  logic [Q*W-1:0]    hold_d, hold_d_nx;
  logic              issue, issue_nx;
  logic [RD_LAT-1:0] issue_pipe;
  logic [Q*AW-1:0]   addr_q, addr_nx;
  logic [Q*W-1:0]    wdata_q, wdata_nx;
  logic              we_q, we_nx;
  logic              start_q, start_nx;
  logic [15:0]       step_cnt, step_nx;
  logic [Q*W-1:0]    coll_data_q;
  logic              coll_valid_q;
  logic              wr_go;
  logic [Q*W-1:0]    wr_data;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state        <= S_SETUP;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      wait_cnt     <= '0;
      phase        <= 1'b0;
      hold_v       <= 1'b0;
      hold_d       <= '0;
      issue        <= 1'b0;
      issue_pipe   <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      start_q      <= 1'b0;
      step_cnt     <= '0;
      coll_data_q  <= '0;
      coll_valid_q <= 1'b0;
    end else begin
      state        <= state_nx;
      rd_cnt       <= rd_nx;
      wr_cnt       <= wr_nx;
      wait_cnt     <= wait_nx;
      phase        <= phase_nx;
      hold_v       <= hold_v_nx;
      hold_d       <= hold_d_nx;
      issue        <= issue_nx;
      issue_pipe   <= (issue_pipe << 1) | RD_LAT'(issue);
      addr_q       <= addr_nx;
      wdata_q      <= wdata_nx;
      we_q         <= we_nx;
      start_q      <= start_nx;
      step_cnt     <= step_nx;
      // Last tap marks the cycle in which the BRAM returns the issued cell
      coll_valid_q <= issue_pipe[RD_LAT-1];
      if (issue_pipe[RD_LAT-1]) begin
        coll_data_q <= bus.bram_data_in;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    rd_nx     = rd_cnt;
    wr_nx     = wr_cnt;
    wait_nx   = wait_cnt;
    phase_nx  = 1'b0;
    hold_v_nx = hold_v;
    hold_d_nx = hold_d;
    issue_nx  = 1'b0;
    addr_nx   = addr_q;
    wdata_nx  = wdata_q;
    we_nx     = 1'b0;
    start_nx  = 1'b0;
    step_nx   = step_cnt;
    wr_go     = 1'b0;
    wr_data   = hold_d;
    unique case (state)
      S_SETUP: begin
        addr_nx  = bus.setup_addr_in;
        wdata_nx = bus.setup_data_in;
        we_nx    = bus.setup_we_in;
        if (bus.setup_done_in) begin
          state_nx = S_WAIT;
          we_nx    = 1'b0;
          wait_nx  = '0;
        end
      end
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          wait_nx   = '0;
          rd_nx     = '0;
          wr_nx     = '0;
          hold_v_nx = 1'b0;
          state_nx  = run_in ? S_COLLIDE : S_PAUSE;
        end else begin
          wait_nx = wait_cnt + 1'b1;
        end
      end
      S_PAUSE: begin
        if (run_in || step_in) begin
          state_nx  = S_COLLIDE;
          rd_nx     = '0;
          wr_nx     = '0;
          hold_v_nx = 1'b0;
        end
      end
      S_COLLIDE: begin
        // Even slots issue reads; odd slots drain a collided cell, parked in hold if it lands early
        phase_nx = ~phase;
        if (!phase) begin
          if (rd_cnt < DEPTH_C) begin
            addr_nx  = {Q{rd_cnt[AW-1:0]}};
            issue_nx = 1'b1;
            rd_nx    = rd_cnt + 1'b1;
          end
          if (bus.coll_valid_in) begin
            hold_v_nx = 1'b1;
            hold_d_nx = bus.coll_data_in;
          end
        end else if (hold_v) begin
          wr_go     = 1'b1;
          wr_data   = hold_d;
          hold_v_nx = bus.coll_valid_in;
          hold_d_nx = bus.coll_data_in;
        end else if (bus.coll_valid_in) begin
          wr_go   = 1'b1;
          wr_data = bus.coll_data_in;
        end
        if (wr_go) begin
          addr_nx  = {Q{wr_cnt[AW-1:0]}};
          wdata_nx = wr_data;
          we_nx    = 1'b1;
          wr_nx    = wr_cnt + 1'b1;
          if (wr_cnt == LAST_C) begin
            state_nx = S_STREAM;
            start_nx = 1'b1;
          end
        end
      end
      S_STREAM: begin
        addr_nx  = bus.stream_addr_in;
        wdata_nx = bus.stream_data_in;
        we_nx    = bus.stream_we_in;
        // A done seen alongside our own start pulse belongs to a previous pass
        if (bus.stream_done_in && !start_q) begin
          state_nx = S_WAIT;
          we_nx    = 1'b0;
          wait_nx  = '0;
          step_nx  = step_cnt + 16'd1;
        end
      end
      default: state_nx = S_SETUP;
    endcase
  end

  assign bus.addr_out         = addr_q;
  assign bus.bram_data_out    = wdata_q;
  assign bus.we_out           = we_q;
  assign bus.coll_data_out    = coll_data_q;
  assign bus.coll_valid_out   = coll_valid_q;
  assign bus.stream_start_out = start_q;
  assign state_out            = state;
  assign step_count_out       = step_cnt;
endmodule
`default_nettype wire
